hdb3_dec_multi: RTL and testbench

- Parametrised multi-lane HDB3/AMI line decoder; successor to the single-lane HDB3 decoder in the E1 receive path.
- Converts ternary symbols into NRZ bits and removes 000V/B00V substitutions in HDB3 mode.
- Detects code violations and keeps a saturating per-lane error count.
- Sits between the line-symbol slicer and the E1 deframer.

---
 rtl/hdb3_pkg.sv | 41 ++++
 rtl/hdb3_dec_lane.sv | 139 +++++++++++++
 rtl/hdb3_dec_multi.sv | 65 ++++++
 tb/tb_hdb3_dec_multi.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared constants, symbol classification and helper for the HDB3/AMI decoder.
package hdb3_pkg;

   // Line symbol encoding from the slicer
   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b10;
   localparam logic [1:0] SYM_ILL  = 2'b11;

   // Line code selection
   localparam logic MODE_AMI  = 1'b0;
   localparam logic MODE_HDB3 = 1'b1;

   // Saturation points for the zero-run tracker and the pipeline fill counter
   localparam logic [2:0] ZRUN_MAX = 3'd4;
   localparam logic [2:0] FILL_MAX = 3'd4;

   // What a symbol means given the lane's pulse history
   typedef enum logic [1:0] {
      SK_ZERO = 2'b00,
      SK_MARK = 2'b01,
      SK_VIOL = 2'b10,
      SK_ILL  = 2'b11
   } sym_kind_e;

   // A pulse repeating the previous pulse polarity is a bipolar violation;
   // polarity is carried as 1 for negative (bit 1 of the symbol).
   function automatic sym_kind_e classify(input logic [1:0] sym,
                                          input logic       seen_pulse,
                                          input logic       last_pol);
      sym_kind_e kind;
      case (sym)
         SYM_ZERO: kind = SK_ZERO;
         SYM_POS,
         SYM_NEG:  kind = (seen_pulse && (sym[1] == last_pol)) ? SK_VIOL : SK_MARK;
         default:  kind = SK_ILL;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/hdb3_dec_lane.sv
// One decoder lane: symbol classification, 4-deep substitution window and
// saturating code-violation counter.
module hdb3_dec_lane
   import hdb3_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             restart,
   input  logic             data_valid,
   input  logic [1:0]       sym,
   input  logic             cnt_clr,
   output logic             dout,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   logic [3:0] sr_r;
   logic [2:0] zero_run_r;
   logic       seen_pulse_r;
   logic       seen_v_r;
   logic       last_pol_r;
   logic       last_v_pol_r;

   sym_kind_e  kind_s;
   logic       pol_s;
   logic       newbit_s;
   logic [2:0] sr_low_s;
   logic       err_s;
   logic [2:0] zero_run_nxt_s;
   logic       seen_pulse_nxt_s;
   logic       seen_v_nxt_s;
   logic       last_pol_nxt_s;
   logic       last_v_pol_nxt_s;
   logic       count_s;

   // Decode the current symbol into the new bit, window edit, error and next history
   always_comb begin
      kind_s           = classify(sym, seen_pulse_r, last_pol_r);
      pol_s            = sym[1];
      newbit_s         = 1'b0;
      sr_low_s         = sr_r[2:0];
      err_s            = 1'b0;
      zero_run_nxt_s   = zero_run_r;
      seen_pulse_nxt_s = seen_pulse_r;
      seen_v_nxt_s     = seen_v_r;
      last_pol_nxt_s   = last_pol_r;
      last_v_pol_nxt_s = last_v_pol_r;
      case (kind_s)
         SK_ZERO: begin
            if (zero_run_r < ZRUN_MAX) begin
               zero_run_nxt_s = zero_run_r + 3'd1;
               err_s = (mode == MODE_HDB3) && (zero_run_r == (ZRUN_MAX - 3'd1));
            end else begin
               zero_run_nxt_s = zero_run_r;
            end
         end
         SK_MARK: begin
            newbit_s         = 1'b1;
            last_pol_nxt_s   = pol_s;
            seen_pulse_nxt_s = 1'b1;
            zero_run_nxt_s   = 3'd0;
         end
         SK_VIOL: begin
            if (mode == MODE_HDB3) begin
               // V pulse: drop it and any B placed three slots earlier
               newbit_s         = 1'b0;
               sr_low_s         = 3'b000;
               err_s            = seen_v_r && (pol_s == last_v_pol_r);
               last_v_pol_nxt_s = pol_s;
               seen_v_nxt_s     = 1'b1;
            end else begin
               newbit_s = 1'b1;
               err_s    = 1'b1;
            end
            last_pol_nxt_s   = pol_s;
            seen_pulse_nxt_s = 1'b1;
            zero_run_nxt_s   = 3'd0;
         end
         default: begin
            newbit_s = 1'b0;
            err_s    = 1'b1;
         end
      endcase
      count_s = data_valid && !restart && err_s;
   end

   // Lane history, delay window and registered bit/error outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_r         <= 4'b0000;
         zero_run_r   <= 3'd0;
         seen_pulse_r <= 1'b0;
         seen_v_r     <= 1'b0;
         last_pol_r   <= 1'b0;
         last_v_pol_r <= 1'b0;
         dout         <= 1'b0;
         err          <= 1'b0;
      end else if (restart) begin
         sr_r         <= 4'b0000;
         zero_run_r   <= 3'd0;
         seen_pulse_r <= 1'b0;
         seen_v_r     <= 1'b0;
         last_pol_r   <= 1'b0;
         last_v_pol_r <= 1'b0;
         err          <= 1'b0;
      end else if (data_valid) begin
         dout         <= sr_r[3];
         sr_r         <= {sr_low_s, newbit_s};
         zero_run_r   <= zero_run_nxt_s;
         seen_pulse_r <= seen_pulse_nxt_s;
         seen_v_r     <= seen_v_nxt_s;
         last_pol_r   <= last_pol_nxt_s;
         last_v_pol_r <= last_v_pol_nxt_s;
         err          <= err_s;
      end else begin
         err          <= 1'b0;
      end
   end

   // Saturating error counter; a clear coinciding with an error leaves a count of one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         err_cnt <= count_s ? CNT_ONE : {CNT_W{1'b0}};
      end else if (count_s && (err_cnt != CNT_SAT)) begin
         err_cnt <= err_cnt + CNT_ONE;
      end else begin
         err_cnt <= err_cnt;
      end
   end

endmodule

// File: rtl/hdb3_dec_multi.sv
// Multi-lane HDB3/AMI decoder: registers the mode, tracks the shared pipeline
// fill and instantiates one decoder lane per channel.
module hdb3_dec_multi
   import hdb3_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic                data_valid,
   input  logic [2*CH-1:0]     HDB3_in,
   output logic [CH-1:0]       dout,
   output logic                dout_valid,
   output logic [CH-1:0]       err,
   output logic [CH*CNT_W-1:0] err_cnt,
   input  logic                cnt_clr
);

   logic       mode_r;
   logic [2:0] fill_r;
   logic       restart_s;

   // A mode change restarts every lane and discards the symbol of that clock
   always_comb begin
      restart_s = (mode != mode_r);
   end

   // Registered mode copy, shared fill counter and output qualifier
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_r     <= MODE_AMI;
         fill_r     <= 3'd0;
         dout_valid <= 1'b0;
      end else if (restart_s) begin
         mode_r     <= mode;
         fill_r     <= 3'd0;
         dout_valid <= 1'b0;
      end else if (data_valid) begin
         dout_valid <= (fill_r == FILL_MAX);
         fill_r     <= (fill_r == FILL_MAX) ? FILL_MAX : (fill_r + 3'd1);
      end else begin
         dout_valid <= 1'b0;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      hdb3_dec_lane #(
         .CNT_W(CNT_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .mode      (mode_r),
         .restart   (restart_s),
         .data_valid(data_valid),
         .sym       (HDB3_in[2*i +: 2]),
         .cnt_clr   (cnt_clr),
         .dout      (dout[i]),
         .err       (err[i]),
         .err_cnt   (err_cnt[CNT_W*i +: CNT_W])
      );
   end

endmodule

// File: tb/tb_hdb3_dec_multi.sv
// Directed self-checking bench for hdb3_dec_multi (4 lanes, 4-bit counters).
module tb_hdb3_dec_multi;
   import hdb3_pkg::*;

   localparam int CH    = 4;
   localparam int CNT_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                mode = 1'b1;
   logic                data_valid = 1'b0;
   logic                cnt_clr = 1'b0;
   logic [2*CH-1:0]     HDB3_in = '0;
   logic [CH-1:0]       dout;
   logic                dout_valid;
   logic [CH-1:0]       err;
   logic [CH*CNT_W-1:0] err_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0] sq[$];
   bit         eb[$];
   int         err_at;
   logic [2*CH-1:0] v;

   hdb3_dec_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .data_valid(data_valid),
      .HDB3_in   (HDB3_in),
      .dout      (dout),
      .dout_valid(dout_valid),
      .err       (err),
      .err_cnt   (err_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*CH-1:0] put(input int ln, input logic [1:0] s);
      logic [2*CH-1:0] r;
      r = '0;
      r[2*ln +: 2] = s;
      return r;
   endfunction

   // Feed sq on lane ln from an empty pipeline; eb holds the decoded bits
   task automatic play(input int ln, input string tag);
      for (int j = 0; j < sq.size(); j++) begin
         HDB3_in    = put(ln, sq[j]);
         data_valid = 1'b1;
         tick();
         chk($sformatf("%s valid[%0d]", tag, j), dout_valid, (j >= 4));
         if (j >= 4) chk($sformatf("%s dout[%0d]", tag, j), dout[ln], eb[j-4]);
         chk($sformatf("%s err[%0d]", tag, j), err[ln], (j == err_at));
      end
      data_valid = 1'b0;
      HDB3_in    = '0;
   endtask

   task automatic restart(input logic m);
      mode = ~m;
      tick();
      mode = m;
      tick();
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst dout", dout, 4'h0);
      chk("rst valid", dout_valid, 1'b0);
      chk("rst err", err, 4'h0);
      chk("rst cnt", err_cnt, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("idle valid", dout_valid, 1'b0);

      // HDB3 000V
      sq = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS};
      eb = '{1, 0, 0, 0, 0};
      err_at = -1;
      play(0, "t1");

      // HDB3 B00V erase, then a same-polarity V
      restart(1'b1);
      sq = '{SYM_POS, SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_NEG, SYM_POS, SYM_NEG, SYM_ZERO,
             SYM_ZERO, SYM_ZERO, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG};
      eb = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      err_at = 10;
      play(0, "t2");
      chk("t2 cnt0", err_cnt[3:0], 4'h1);

      // AMI bipolar violation on lane 1
      mode = 1'b0;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t3 clr", err_cnt, 16'h0000);
      sq = '{SYM_POS, SYM_NEG, SYM_POS, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS};
      eb = '{1, 1, 1, 1};
      err_at = 3;
      play(1, "t3");
      chk("t3 cnt", err_cnt, 16'h0010);

      // HDB3 illegal symbol on lane 2, four zeros on lane 3
      restart(1'b1);
      sq = '{SYM_POS, SYM_ILL, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS};
      eb = '{1, 0, 1, 1};
      err_at = 1;
      play(2, "t4a");
      restart(1'b1);
      sq = '{SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG};
      eb = '{0, 0, 0, 0};
      err_at = 3;
      play(3, "t4b");

      // Counter saturation and clear interaction
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t5 clr", err_cnt, 16'h0000);
      HDB3_in = {CH{SYM_ILL}};
      data_valid = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      chk("t5 sat", err_cnt, 16'hFFFF);
      chk("t5 err", err, 4'hF);
      cnt_clr = 1'b1;
      tick();
      chk("t5 clr+err", err_cnt, 16'h1111);
      data_valid = 1'b0;
      tick();
      cnt_clr = 1'b0;
      chk("t5 clr only", err_cnt, 16'h0000);

      // Asynchronous reset with a full pipeline
      restart(1'b1);
      for (int k = 0; k < 5; k++) begin
         v = put(0, (k % 2 == 0) ? SYM_POS : SYM_NEG);
         v[3:2] = SYM_ILL;
         HDB3_in = v;
         data_valid = 1'b1;
         tick();
      end
      data_valid = 1'b0;
      chk("t6 pre valid", dout_valid, 1'b1);
      chk("t6 pre dout0", dout[0], 1'b1);
      chk("t6 pre cnt1", err_cnt[7:4], 4'h5);
      #2;
      rst = 1'b0;
      #1;
      chk("t6 rst dout", dout, 4'h0);
      chk("t6 rst valid", dout_valid, 1'b0);
      chk("t6 rst err", err, 4'h0);
      chk("t6 rst cnt", err_cnt, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      tick();
      sq = '{SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG};
      eb = '{1, 1};
      err_at = -1;
      play(0, "t6");
      chk("t6 cnt", err_cnt, 16'h1110);

      // Mode toggle mid-stream discards the symbol and keeps counters
      mode = 1'b0;
      HDB3_in = {CH{SYM_ILL}};
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("t7 toggle valid", dout_valid, 1'b0);
      chk("t7 toggle err", err, 4'h0);
      chk("t7 toggle cnt", err_cnt, 16'h1110);
      sq = '{SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS};
      eb = '{1};
      err_at = -1;
      play(0, "t7");
      chk("t7 cnt", err_cnt, 16'h1110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
